// File: rtl/activation_search_unit.sv
// activation_search_unit
// Binary-searches a sorted signed tag ROM for the largest tag not above the
// incoming sum. It then reads that entry from the activation ROM, which holds
// sigmoid in the upper half and tanh in the lower half of each word.
// ReLU and identity bypass both ROMs.
//
// state     | meaning
// ----------+---------------------------------------------------------
// S_IDLE    | in_ready high, waiting for a request
// S_PROBE   | tag_rd/tag_addr=mid on the bus for this cycle
// S_COMPARE | tag_data valid, narrow [lo,hi] or finish the search
// S_FETCH   | act_rd/act_addr=best on the bus for this cycle
// S_CAPTURE | act_data valid, form the result
// S_DONE    | out_valid high, result held until out_ready
module activation_search_unit #(
    parameter int DATAWIDTH = 16,
    parameter int INWIDTH   = 10
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATAWIDTH-1:0]   sum,
    input  logic [1:0]             func,
    output logic [INWIDTH-1:0]     tag_addr,
    output logic                   tag_rd,
    input  logic [DATAWIDTH-1:0]   tag_data,
    output logic [INWIDTH-1:0]     act_addr,
    output logic                   act_rd,
    input  logic [2*DATAWIDTH-1:0] act_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATAWIDTH-1:0]   activation_value,
    output logic [DATAWIDTH-1:0]   tag_value,
    output logic [INWIDTH-1:0]     tag_index,
    output logic                   saturated
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PROBE,
        S_COMPARE,
        S_FETCH,
        S_CAPTURE,
        S_DONE
    } state_t;

    // lo/hi carry one extra bit so lo = max+1 is representable and simply
    // compares greater than hi instead of wrapping to zero.
    localparam logic [INWIDTH:0]   MAX_BOUND = {1'b0, {INWIDTH{1'b1}}};
    localparam logic [INWIDTH:0]   ONE       = {{INWIDTH{1'b0}}, 1'b1};
    localparam logic [INWIDTH-1:0] MAX_IDX   = {INWIDTH{1'b1}};

    state_t                        state_q, state_d;
    logic signed [DATAWIDTH-1:0]   sum_q, sum_d;
    logic                          tanh_sel_q, tanh_sel_d;
    logic [INWIDTH:0]              lo_q, lo_d, hi_q, hi_d;
    logic [INWIDTH-1:0]            best_q, best_d;
    logic signed [DATAWIDTH-1:0]   best_tag_q, best_tag_d;
    logic                          below_q, below_d;
    logic                          in_ready_q, in_ready_d;
    logic [INWIDTH-1:0]            tag_addr_q, tag_addr_d;
    logic                          tag_rd_q, tag_rd_d;
    logic [INWIDTH-1:0]            act_addr_q, act_addr_d;
    logic                          act_rd_q, act_rd_d;
    logic                          out_valid_q, out_valid_d;
    logic [DATAWIDTH-1:0]          act_value_q, act_value_d;
    logic [DATAWIDTH-1:0]          tag_value_q, tag_value_d;
    logic [INWIDTH-1:0]            tag_index_q, tag_index_d;
    logic                          saturated_q, saturated_d;

    logic [INWIDTH:0]              lo_n, hi_n;
    logic [INWIDTH-1:0]            best_n, mid;
    logic                          search_done;

    function automatic logic [INWIDTH-1:0] mid_of(input logic [INWIDTH:0] a,
                                                  input logic [INWIDTH:0] b);
        logic [INWIDTH:0] s;
        s = a + b;
        return s[INWIDTH:1];
    endfunction

    // Next-state and next-output computation; the probe address register
    // doubles as the current mid point during COMPARE.
    always_comb begin
        state_d     = state_q;
        sum_d       = sum_q;
        tanh_sel_d  = tanh_sel_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        best_d      = best_q;
        best_tag_d  = best_tag_q;
        below_d     = below_q;
        in_ready_d  = in_ready_q;
        tag_addr_d  = tag_addr_q;
        tag_rd_d    = 1'b0;
        act_addr_d  = act_addr_q;
        act_rd_d    = 1'b0;
        out_valid_d = out_valid_q;
        act_value_d = act_value_q;
        tag_value_d = tag_value_q;
        tag_index_d = tag_index_q;
        saturated_d = saturated_q;
        lo_n        = lo_q;
        hi_n        = hi_q;
        best_n      = best_q;
        mid         = tag_addr_q;
        search_done = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    in_ready_d = 1'b0;
                    sum_d      = sum;
                    tanh_sel_d = func[0];
                    if (func[1]) begin
                        // ReLU clamps negatives; identity passes sum through.
                        act_value_d = (!func[0] && sum[DATAWIDTH-1]) ? '0 : sum;
                        tag_value_d = sum;
                        tag_index_d = '0;
                        saturated_d = 1'b0;
                        out_valid_d = 1'b1;
                        state_d     = S_DONE;
                    end else begin
                        lo_d       = '0;
                        hi_d       = MAX_BOUND;
                        best_d     = '0;
                        best_tag_d = '0;
                        below_d    = 1'b0;
                        tag_addr_d = mid_of('0, MAX_BOUND);
                        tag_rd_d   = 1'b1;
                        state_d    = S_PROBE;
                    end
                end
            end
            S_PROBE: begin
                state_d = S_COMPARE;
            end
            S_COMPARE: begin
                if ($signed(tag_data) == sum_q) begin
                    best_n      = mid;
                    best_tag_d  = tag_data;
                    search_done = 1'b1;
                end else if ($signed(tag_data) < sum_q) begin
                    best_n     = mid;
                    best_tag_d = tag_data;
                    lo_n       = {1'b0, mid} + ONE;
                end else if (mid == '0) begin
                    // Sum lies below tag[0]; stop rather than let hi wrap.
                    below_d     = 1'b1;
                    best_tag_d  = tag_data;
                    search_done = 1'b1;
                end else begin
                    hi_n = {1'b0, mid} - ONE;
                end
                if (lo_n > hi_n) begin
                    search_done = 1'b1;
                end
                lo_d   = lo_n;
                hi_d   = hi_n;
                best_d = best_n;
                if (search_done) begin
                    act_addr_d = best_n;
                    act_rd_d   = 1'b1;
                    state_d    = S_FETCH;
                end else begin
                    tag_addr_d = mid_of(lo_n, hi_n);
                    tag_rd_d   = 1'b1;
                    state_d    = S_PROBE;
                end
            end
            S_FETCH: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                act_value_d = tanh_sel_q ? act_data[DATAWIDTH-1:0]
                                         : act_data[2*DATAWIDTH-1:DATAWIDTH];
                tag_value_d = best_tag_q;
                tag_index_d = best_q;
                // best_tag <= sum always holds, so inequality at the top
                // entry means the sum is beyond the table.
                saturated_d = below_q || ((best_q == MAX_IDX) && (best_tag_q != sum_q));
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d     = S_IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any search immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sum_q       <= '0;
            tanh_sel_q  <= 1'b0;
            lo_q        <= '0;
            hi_q        <= '0;
            best_q      <= '0;
            best_tag_q  <= '0;
            below_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            tag_addr_q  <= '0;
            tag_rd_q    <= 1'b0;
            act_addr_q  <= '0;
            act_rd_q    <= 1'b0;
            out_valid_q <= 1'b0;
            act_value_q <= '0;
            tag_value_q <= '0;
            tag_index_q <= '0;
            saturated_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sum_q       <= sum_d;
            tanh_sel_q  <= tanh_sel_d;
            lo_q        <= lo_d;
            hi_q        <= hi_d;
            best_q      <= best_d;
            best_tag_q  <= best_tag_d;
            below_q     <= below_d;
            in_ready_q  <= in_ready_d;
            tag_addr_q  <= tag_addr_d;
            tag_rd_q    <= tag_rd_d;
            act_addr_q  <= act_addr_d;
            act_rd_q    <= act_rd_d;
            out_valid_q <= out_valid_d;
            act_value_q <= act_value_d;
            tag_value_q <= tag_value_d;
            tag_index_q <= tag_index_d;
            saturated_q <= saturated_d;
        end
    end

    assign in_ready         = in_ready_q;
    assign tag_addr         = tag_addr_q;
    assign tag_rd           = tag_rd_q;
    assign act_addr         = act_addr_q;
    assign act_rd           = act_rd_q;
    assign out_valid        = out_valid_q;
    assign activation_value = act_value_q;
    assign tag_value        = tag_value_q;
    assign tag_index        = tag_index_q;
    assign saturated        = saturated_q;

endmodule

// File: tb/tb_activation_search_unit.sv
// Testbench for activation_search_unit: ROM models, scoreboard and monitor.
module tb_activation_search_unit;

    localparam int DW = 16;
    localparam int IW = 10;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] sum = '0;
    logic [1:0]    func = 2'b00;
    logic [IW-1:0] tag_addr;
    logic          tag_rd;
    logic [DW-1:0] tag_data = '0;
    logic [IW-1:0] act_addr;
    logic          act_rd;
    logic [2*DW-1:0] act_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] activation_value;
    logic [DW-1:0] tag_value;
    logic [IW-1:0] tag_index;
    logic          saturated;

    activation_search_unit #(.DATAWIDTH(DW), .INWIDTH(IW)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .sum(sum), .func(func),
        .tag_addr(tag_addr), .tag_rd(tag_rd), .tag_data(tag_data),
        .act_addr(act_addr), .act_rd(act_rd), .act_data(act_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .activation_value(activation_value), .tag_value(tag_value),
        .tag_index(tag_index), .saturated(saturated)
    );

    always #5 clock = ~clock;

    typedef struct {
        int acc;
        int act;
        int tagv;
        int idx;
        int sat;
        int lat;
        int ntag;
        int nact;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   transfers = 0;
    bit   auto_ready = 1'b1;

    always @(posedge clock) cyc <= cyc + 1;

    // Synchronous ROM models: tag[i] = 16*(i-512), act[i] = {i, ~i}.
    always @(posedge clock) begin
        if (tag_rd) tag_data <= 16'(16 * (int'(tag_addr) - 512));
        if (act_rd) act_data <= {16'(act_addr), ~16'(act_addr)};
    end

    function automatic int rom_tag(int i);
        return 16 * (i - 512);
    endfunction

    task automatic chk(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, a, e, $time);
        end
    endtask

    // Number of tag probes the described search takes for a given sum.
    function automatic int probe_count(int s);
        int lo = 0, hi = 1023, p = 0, mid, t;
        while (1) begin
            mid = (lo + hi) / 2;
            p++;
            t = rom_tag(mid);
            if (t == s) break;
            if (t < s) lo = mid + 1;
            else begin
                if (mid == 0) break;
                hi = mid - 1;
            end
            if (lo > hi) break;
        end
        return p;
    endfunction

    function automatic exp_t predict(int s, logic [1:0] f, int acc);
        exp_t e;
        logic [15:0] w;
        int idx;
        e.acc = acc;
        if (f[1]) begin
            e.act  = (!f[0] && s < 0) ? 0 : s;
            e.tagv = s;
            e.idx  = 0;
            e.sat  = 0;
            e.lat  = 1;
            e.ntag = 0;
            e.nact = 0;
        end else begin
            idx = 0;
            for (int i = 0; i < 1024; i++) if (rom_tag(i) <= s) idx = i;
            w = f[0] ? ~16'(idx) : 16'(idx);
            e.act  = int'($signed(w));
            e.tagv = rom_tag(idx);
            e.idx  = idx;
            e.sat  = (s < rom_tag(0) || s > rom_tag(1023)) ? 1 : 0;
            e.ntag = probe_count(s);
            e.lat  = 2 * e.ntag + 3;
            e.nact = 1;
        end
        return e;
    endfunction

    // Called at posedge+1; returns at posedge+1 after the acceptance edge.
    task automatic send(input int s, input logic [1:0] f);
        int n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clock); #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready got 0 expected 1");
            return;
        end
        in_valid = 1'b1;
        sum      = 16'(s);
        func     = f;
        q.push_back(predict(s, f, cyc + 1));
        @(posedge clock); #1;
        in_valid = 1'b0;
        sum      = 16'($urandom);
        func     = 2'($urandom);
    endtask

    always @(posedge clock) begin
        #1;
        if (auto_ready) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: pops the scoreboard on the first cycle of each result and
    // checks the result stays frozen until it is taken.
    bit   holding = 1'b0;
    int   ntag = 0, nact = 0;
    int   h_act, h_tagv, h_idx, h_sat;
    exp_t e;

    always @(negedge clock) begin
        if (reset) begin
            holding = 1'b0;
            ntag    = 0;
            nact    = 0;
        end else begin
            chk("strobe_exclusive", int'(tag_rd && act_rd), 0);
            ntag += int'(tag_rd);
            nact += int'(act_rd);
            if (out_valid) begin
                chk("in_ready_busy", int'(in_ready), 0);
                if (!holding) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_output: got out_valid expected none");
                    end else begin
                        e = q.pop_front();
                        chk("activation_value", int'($signed(activation_value)), e.act);
                        chk("tag_value", int'($signed(tag_value)), e.tagv);
                        chk("tag_index", int'(tag_index), e.idx);
                        chk("saturated", int'(saturated), e.sat);
                        chk("latency", cyc + 1 - e.acc, e.lat);
                        chk("tag_rd_count", ntag, e.ntag);
                        chk("act_rd_count", nact, e.nact);
                    end
                    holding = 1'b1;
                    h_act   = int'(activation_value);
                    h_tagv  = int'(tag_value);
                    h_idx   = int'(tag_index);
                    h_sat   = int'(saturated);
                end else begin
                    chk("hold_act", int'(activation_value), h_act);
                    chk("hold_tagv", int'(tag_value), h_tagv);
                    chk("hold_idx", int'(tag_index), h_idx);
                    chk("hold_sat", int'(saturated), h_sat);
                end
                if (out_ready) begin
                    holding = 1'b0;
                    transfers++;
                    ntag = 0;
                    nact = 0;
                end
            end else if (holding) begin
                chk("valid_dropped", 0, 1);
                holding = 1'b0;
            end
        end
    end

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 1);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_tag_rd"}, int'(tag_rd), 0);
        chk({tag, "_act_rd"}, int'(act_rd), 0);
        chk({tag, "_tag_addr"}, int'(tag_addr), 0);
        chk({tag, "_act_addr"}, int'(act_addr), 0);
        chk({tag, "_act_value"}, int'(activation_value), 0);
        chk({tag, "_tag_value"}, int'(tag_value), 0);
        chk({tag, "_tag_index"}, int'(tag_index), 0);
        chk({tag, "_saturated"}, int'(saturated), 0);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || holding) && n < 3000) begin
            @(posedge clock); #1;
            n++;
        end
        if (q.size() != 0 || holding) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: pending %0d expected 0", q.size());
            q.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int t0;
        int s;
        #12;
        chk_reset_outputs("reset");
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        // Directed cases from the ROM model.
        send(0, 2'b00);
        send(37, 2'b01);
        send(-9000, 2'b00);
        send(9000, 2'b00);
        send(8176, 2'b01);
        send(-8192, 2'b00);
        send(-5, 2'b10);
        send(300, 2'b10);
        send(-1234, 2'b11);
        drain();

        // Backpressure: result held 20 cycles while inputs churn.
        auto_ready = 1'b0;
        out_ready  = 1'b0;
        send(1234, 2'b01);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clock); #1;
            n++;
        end
        chk("bp_out_valid", int'(out_valid), 1);
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            in_valid = 1'(($urandom));
            sum      = 16'($urandom);
            func     = 2'($urandom);
            chk("bp_in_ready", int'(in_ready), 0);
        end
        @(posedge clock); #1;
        in_valid  = 1'b0;
        t0        = transfers;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clock); #1;
        end
        chk("bp_one_transfer", transfers - t0, 1);
        chk("bp_in_ready_after", int'(in_ready), 1);
        auto_ready = 1'b1;

        // Reset during COMPARE aborts the search.
        send(-300, 2'b01);
        n = 0;
        while (!tag_rd && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("abort_saw_probe", int'(tag_rd), 1);
        @(posedge clock); #1;
        reset = 1'b1;
        #1;
        q.delete();
        chk_reset_outputs("abort");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("abort_no_strobe", int'(tag_rd || act_rd || out_valid), 0);
        end
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        send(37, 2'b01);
        drain();

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: s = int'($signed(16'($urandom)));
                1: s = 16 * (int'($urandom_range(0, 1023)) - 512);
                default: s = int'($urandom_range(0, 18000)) - 9000;
            endcase
            send(s, 2'($urandom_range(0, 3)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
